// File: rtl/mult_cdb_buffer_pkg.sv
// Shared multiplier/CDB definitions: completion-entry layout and default buffer depth.
// Imported by the completion buffer and by anything that builds or consumes its entries.
package mult_cdb_buffer_pkg;

    localparam int AR_W      = 5;
    localparam int PR_W      = 7;
    localparam int DATA_W    = 64;
    localparam int CDB_DEPTH = 8;

    typedef struct packed {
        logic [AR_W-1:0]   ar_idx;
        logic [PR_W-1:0]   pr_idx;
        logic [DATA_W-1:0] result;
        logic              exception;
    } cdb_entry_t;

endpackage

// File: rtl/mult_cdb_buffer.sv
// Two-lane in-order completion buffer between the multiplier and the CDB,
// with an issue-credit counter that keeps the RS from oversubscribing the buffer.
module mult_cdb_buffer
    import mult_cdb_buffer_pkg::*;
#(
    parameter int DEPTH = CDB_DEPTH,
    parameter int CNT_W = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              rs_issue0,
    input  logic              rs_issue1,

    input  logic              fu_complete0,
    input  logic              fu_complete1,
    input  logic [AR_W-1:0]   fu_dest_ar_idx0,
    input  logic [AR_W-1:0]   fu_dest_ar_idx1,
    input  logic [PR_W-1:0]   fu_dest_pr_idx0,
    input  logic [PR_W-1:0]   fu_dest_pr_idx1,
    input  logic [DATA_W-1:0] fu_result0,
    input  logic [DATA_W-1:0] fu_result1,
    input  logic              fu_exception0,
    input  logic              fu_exception1,

    input  logic              cdb_grant0,
    input  logic              cdb_grant1,

    output logic              cdb_valid0,
    output logic              cdb_valid1,
    output logic [AR_W-1:0]   cdb_dest_ar_idx0,
    output logic [AR_W-1:0]   cdb_dest_ar_idx1,
    output logic [PR_W-1:0]   cdb_dest_pr_idx0,
    output logic [PR_W-1:0]   cdb_dest_pr_idx1,
    output logic [DATA_W-1:0] cdb_result0,
    output logic [DATA_W-1:0] cdb_result1,
    output logic              cdb_exception0,
    output logic              cdb_exception1,

    output logic [1:0]        rs_mult_avail,
    output logic [CNT_W-1:0]  buf_count,
    output logic              overflow_err
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    cdb_entry_t mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic             overflow_q, overflow_d;

    logic             deq0, deq1, enq0, enq1, acc0, acc1, drop;
    logic [CNT_W-1:0] deq_n, enq_n, acc_n, space, credit_sum;
    logic [PTR_W-1:0] wr_idx0, wr_idx1, head_nx;
    cdb_entry_t       wr_entry0, wr_entry1, head_entry, next_entry;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rs_mult_avail = 2'b00;
        if (credit_q >= CNT_W'(2))
            rs_mult_avail = 2'b11;
        else if (credit_q == CNT_W'(1))
            rs_mult_avail = 2'b01;

        // Lane 1 may only pop together with lane 0, keeping dequeue strictly in order.
        deq0  = cdb_grant0 && (count_q != '0);
        deq1  = deq0 && cdb_grant1 && (count_q >= CNT_W'(2));
        deq_n = CNT_W'(deq0) + CNT_W'(deq1);

        // Slots freed by this cycle's pops are reusable by this cycle's completions.
        space = DEPTH_C - count_q + deq_n;
        enq0  = fu_complete0 && (space != '0);
        enq1  = fu_complete1 && (space > CNT_W'(enq0));
        enq_n = CNT_W'(enq0) + CNT_W'(enq1);
        drop  = (fu_complete0 && !enq0) || (fu_complete1 && !enq1);

        wr_idx0 = tail_q;
        wr_idx1 = tail_q + PTR_W'(enq0);

        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + enq_n - deq_n;

        acc0  = rs_issue0 && rs_mult_avail[0];
        acc1  = rs_issue1 && rs_mult_avail[1];
        acc_n = CNT_W'(acc0) + CNT_W'(acc1);

        // Accepted issues never exceed the credit, so only the upper bound needs clamping.
        credit_sum = credit_q - acc_n + deq_n;
        credit_d   = (credit_sum > DEPTH_C) ? DEPTH_C : credit_sum;

        overflow_d = overflow_q || drop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            credit_q   <= DEPTH_C;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_entry0 = '{ar_idx: fu_dest_ar_idx0, pr_idx: fu_dest_pr_idx0,
                         result: fu_result0, exception: fu_exception0};
    assign wr_entry1 = '{ar_idx: fu_dest_ar_idx1, pr_idx: fu_dest_pr_idx1,
                         result: fu_result1, exception: fu_exception1};

    // NOTE: the storage array is not reset; occupancy is tracked by count_q, so stale
    // contents are never presented as valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (enq0) mem[wr_idx0] <= wr_entry0;
            if (enq1) mem[wr_idx1] <= wr_entry1;
        end
    end

    assign head_nx    = head_q + PTR_W'(1);
    assign head_entry = mem[head_q];
    assign next_entry = mem[head_nx];

    assign cdb_valid0       = (count_q != '0);
    assign cdb_valid1       = (count_q >= CNT_W'(2));
    assign cdb_dest_ar_idx0 = head_entry.ar_idx;
    assign cdb_dest_pr_idx0 = head_entry.pr_idx;
    assign cdb_result0      = head_entry.result;
    assign cdb_exception0   = head_entry.exception;
    assign cdb_dest_ar_idx1 = next_entry.ar_idx;
    assign cdb_dest_pr_idx1 = next_entry.pr_idx;
    assign cdb_result1      = next_entry.result;
    assign cdb_exception1   = next_entry.exception;

    assign buf_count    = count_q;
    assign overflow_err = overflow_q;

endmodule
